// File: rtl/alu_result_stage_pkg.sv
// Shared constants for the ALU result stage:
// condition codes, CCR bit positions and field widths.
package alu_result_stage_pkg;

    localparam int FLAGW = 4;
    localparam int CONDW = 4;

    // CCR bit positions within {C,Z,N,V}
    localparam int CCR_C = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_N = 1;
    localparam int CCR_V = 0;

    localparam logic [CONDW-1:0] COND_AL  = 4'h0;
    localparam logic [CONDW-1:0] COND_EQ  = 4'h1;
    localparam logic [CONDW-1:0] COND_NE  = 4'h2;
    localparam logic [CONDW-1:0] COND_GTU = 4'h3;
    localparam logic [CONDW-1:0] COND_GEU = 4'h4;
    localparam logic [CONDW-1:0] COND_LTU = 4'h5;
    localparam logic [CONDW-1:0] COND_LEU = 4'h6;
    localparam logic [CONDW-1:0] COND_GT  = 4'h7;
    localparam logic [CONDW-1:0] COND_GE  = 4'h8;
    localparam logic [CONDW-1:0] COND_LT  = 4'h9;
    localparam logic [CONDW-1:0] COND_LE  = 4'hA;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream/downstream bundle for the ALU result stage.
// master drives ALU op + out_ready; slave is the stage.
interface alu_result_stage_if #(
    parameter int WIDTH = 32,
    parameter int REGW  = 4
);
    import alu_result_stage_pkg::*;

    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] alu_out_i;
    logic             alu_c_i;
    logic             alu_z_i;
    logic             alu_n_i;
    logic             alu_v_i;
    logic             set_flags_i;
    logic             wr_en_i;
    logic [REGW-1:0]  dest_i;
    logic             is_branch_i;
    logic [CONDW-1:0] cond_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             wr_en_o;
    logic [REGW-1:0]  dest_o;
    logic             br_taken_o;
    logic [FLAGW-1:0] ccr_o;

    modport master (
        output flush_i, in_valid_i, alu_out_i,
        output alu_c_i, alu_z_i, alu_n_i, alu_v_i,
        output set_flags_i, wr_en_i, dest_i,
        output is_branch_i, cond_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o,
        input  wr_en_o, dest_o, br_taken_o, ccr_o
    );

    modport slave (
        input  flush_i, in_valid_i, alu_out_i,
        input  alu_c_i, alu_z_i, alu_n_i, alu_v_i,
        input  set_flags_i, wr_en_i, dest_i,
        input  is_branch_i, cond_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o,
        output wr_en_o, dest_o, br_taken_o, ccr_o
    );

endinterface

// File: rtl/alu_result_stage_cond_eval.sv
// Branch condition evaluator.
// Ports: cond_i (code), ccr_i ({C,Z,N,V}) -> taken_o.
module cond_eval
    import alu_result_stage_pkg::*;
(
    input  logic [CONDW-1:0] cond_i,
    input  logic [FLAGW-1:0] ccr_i,
    output logic             taken_o
);

    logic c, z, lt;

    assign c  = ccr_i[CCR_C];
    assign z  = ccr_i[CCR_Z];
    assign lt = ccr_i[CCR_N] ^ ccr_i[CCR_V];

    always_comb begin
        taken_o = 1'b0;
        unique case (cond_i)
            COND_AL:  taken_o = 1'b1;
            COND_EQ:  taken_o = z;
            COND_NE:  taken_o = !z;
            COND_GTU: taken_o = !c && !z;
            COND_GEU: taken_o = !c;
            COND_LTU: taken_o = c;
            COND_LEU: taken_o = c || z;
            COND_GT:  taken_o = !z && !lt;
            COND_GE:  taken_o = !lt;
            COND_LT:  taken_o = lt;
            COND_LE:  taken_o = z || lt;
            default:  taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: 2-entry result buffer, CCR
// owner, in-order branch resolution at commit.
// Ports: clk_i, rst_i (sync, active-high), bus (slave).
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 4
) (
    input logic         clk_i,
    input logic         rst_i,
    alu_result_stage_if.slave bus
);

    logic [WIDTH-1:0] res_q  [2];
    logic [FLAGW-1:0] flg_q  [2];
    logic             sf_q   [2];
    logic             we_q   [2];
    logic [REGW-1:0]  dst_q  [2];
    logic             br_q   [2];
    logic [CONDW-1:0] cnd_q  [2];

    logic [1:0]       count_q, count_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [FLAGW-1:0] ccr_q;

    logic full, valid, push, pop, taken;

    assign full  = (count_q == 2'd2);
    assign valid = (count_q != 2'd0);
    assign push  = bus.in_valid_i && bus.in_ready_o;
    assign pop   = valid && bus.out_ready_i;

    assign bus.in_ready_o  = !full && !bus.flush_i;
    assign bus.out_valid_o = valid;
    assign bus.result_o    = res_q[rd_q];
    assign bus.dest_o      = dst_q[rd_q];
    assign bus.wr_en_o     = valid && we_q[rd_q];
    assign bus.br_taken_o  = valid && br_q[rd_q] && taken;
    assign bus.ccr_o       = ccr_q;

    // Evaluated against the committed CCR, never the head's own flags
    cond_eval u_cond (
        .cond_i  (cnd_q[rd_q]),
        .ccr_i   (ccr_q),
        .taken_o (taken)
    );

    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (bus.flush_i) begin
            count_d = 2'd0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end else begin
            if (push) wr_d = !wr_q;
            if (pop)  rd_d = !rd_q;
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ccr_q   <= '0;
        end else begin
            // A pop during flush still commits its flags
            if (pop && sf_q[rd_q]) ccr_q <= flg_q[rd_q];
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            res_q[wr_q] <= bus.alu_out_i;
            flg_q[wr_q] <= {bus.alu_c_i, bus.alu_z_i,
                            bus.alu_n_i, bus.alu_v_i};
            sf_q[wr_q]  <= bus.set_flags_i;
            we_q[wr_q]  <= bus.wr_en_i;
            dst_q[wr_q] <= bus.dest_i;
            br_q[wr_q]  <= bus.is_branch_i;
            cnd_q[wr_q] <= bus.cond_i;
        end
    end

endmodule
